rect_fill_engine: RTL
=====================

# rect_fill_engine

Rectangle fill engine that sits directly upstream of the double-buffered SPRAM framebuffer. It accepts one rectangle command at a time over a valid/ready handshake. It clips the rectangle to the 256x128 framebuffer and emits one pixel write per cycle, in row-major order, on the framebuffer write port (`we`/`wx`/`wy`/`wc`). It replaces free-running pattern generators as the drawing source for the back buffer.

## Interface
- `FB_W`, 256: framebuffer width in pixels; fixes `wx` at 8 bits.
- `FB_H`, 128: framebuffer height in pixels; fixes `wy` at 7 bits.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high. Aborts any fill in progress.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_x`  in  8  left column, 0..255.
- `cmd_y`  in  7  top row, 0..127.
- `cmd_w`  in  9  width, 0..256.
- `cmd_h`  in  8  height, 0..128.
- `cmd_color`  in  12  fill colour, {b[3:0], g[3:0], r[3:0]}.
- `fb_ready`  in  1  framebuffer accepts a write this cycle.
- `we`  out  1  write strobe.
- `wx`  out  8  write column.
- `wy`  out  7  write row.
- `wc`  out  12  write colour.
- `busy`  out  1  a command is in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, FILL, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch the command and compute the clipped extents:
    - x_last = min(cmd_x+cmd_w-1, 255), computed 9 bits wide.
    - y_last = min(cmd_y+cmd_h-1, 127), computed 8 bits wide.
  - If cmd_w==0 or cmd_h==0, go to DONE; no writes are issued.
  - Otherwise load wx=cmd_x, wy=cmd_y, wc=cmd_color, set we=1, and go to FILL.
- **FILL**
  - `we`=1. A write is consumed on any cycle with `we`&&`fb_ready`.
  - While `fb_ready`=0, `we`, `wx`, `wy` and `wc` hold unchanged.
  - On a consumed write:
    - If wx<x_last: wx++.
    - Else if wy<y_last: wx=latched cmd_x, wy++.
    - Else: we=0, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle; `cmd_ready`=0.
  - Next state is IDLE.
- `busy` is high in FILL and DONE.
- Clipping only truncates the right and bottom edges; the start coordinates are always in range by width.
- Pixels written per command = (x_last-cmd_x+1)*(y_last-cmd_y+1). There is no wrap-around.
- `cmd_*` inputs are ignored outside the IDLE handshake cycle. The latched colour is stable for the whole command.

## Timing
- Reset values: `we`=0, `wx`=0, `wy`=0, `wc`=0, `done`=0, `busy`=0. The state is IDLE, so `cmd_ready`=1 in the cycle after `rst` is sampled high.
- `rst` is asserted mid-FILL: the next cycle has `we`=0 and no `done`. The partially filled rectangle is left as written.
- All outputs are registered. `cmd_ready` is decoded from state only, with no combinational path from `cmd_valid`.
- Latency from acceptance (cycle N) to the first `we`=1 is 1 cycle (N+1).
- With `fb_ready` held high, the last write is in cycle N+P, where P is the pixel count. `done` is in cycle N+P+1, and the next accept can occur in cycle N+P+2.
- Zero-size command: `done` is in cycle N+1, with `we` never asserted.
- Throughput is 1 pixel/cycle with `fb_ready`=1, plus 2 overhead cycles per command.
- Back-to-back commands are not pipelined; this is accepted as a throughput cost.

## Structure
- Shared package `gfx_pkg`:
  - `FB_W` and `FB_H` localparams.
  - `color_t` (logic [11:0]).
  - `fb_x_t` (logic [7:0]) and `fb_y_t` (logic [6:0]).
  - `rect_cmd_t` packed struct {x, y, w, h, color}.
  - `fill_state_t` enum {IDLE, FILL, DONE}.
- Single module, no sub-modules. The clip computation is small combinational logic on the accept cycle.

## Test plan
- **Basic fill:** cmd (x=10, y=5, w=3, h=2, color=12'hF00), `fb_ready`=1 → writes (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), all wc=F00. `done` 7 cycles after accept, `cmd_ready` high again the cycle after.
- **Clipping:** cmd (x=250, y=120, w=20, h=20) → writes x=250..255 and y=120..127, i.e. 48 writes. No wx or wy wrap occurs.
- **Zero size:** cmd w=0, h=5 → `we` never high; `done` is 1 cycle after accept.
- **Back-pressure:** 2x2 cmd with `fb_ready` toggling 1,0,0,1,0,1,1 → `wx`/`wy`/`wc` hold while stalled. Exactly 4 writes are consumed in row-major order, and `done` follows the 4th consumed write by 1 cycle.
- **Full screen:** cmd (0, 0, 256, 128, 12'h0A5) → 32768 writes. The last write is at (255,127). `done` is at accept+32769.
- **Reset mid-fill:** assert `rst` at the 5th write of a 10x10 fill → next cycle `we`=0, `done`=0, outputs at reset values. `cmd_ready`=1 after `rst` deasserts, and a new command is accepted normally.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared framebuffer geometry, pixel types and rectangle command payload.
package gfx_pkg;

  localparam int unsigned FB_W = 256;
  localparam int unsigned FB_H = 128;

  typedef logic [11:0] color_t;
  typedef logic [7:0]  fb_x_t;
  typedef logic [6:0]  fb_y_t;

  typedef struct packed {
    fb_x_t      x;
    fb_y_t      y;
    logic [8:0] w;
    logic [7:0] h;
    color_t     color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a command to the framebuffer and streams
// one pixel write per accepted cycle in row-major order.
module rect_fill_engine
  import gfx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  input  logic        fb_ready,
  output logic        we,
  output logic [7:0]  wx,
  output logic [6:0]  wy,
  output logic [11:0] wc,
  output logic        busy,
  output logic        done
);

  fill_state_t state_q, state_d;
  rect_cmd_t   cmd;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  fb_x_t       clip_x, x0_q, x0_d, xl_q, xl_d, wx_d;
  fb_y_t       clip_y, yl_q, yl_d, wy_d;
  color_t      wc_d;
  logic        we_d, done_d, busy_d, ready_d;

  // Clip right/bottom edges of the incoming command (only used on accept).
  always_comb begin
    cmd    = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
    sum_x  = 9'(cmd.x) + cmd.w - 9'd1;
    sum_y  = 8'(cmd.y) + cmd.h - 8'd1;
    clip_x = (sum_x > 9'(FB_W - 1)) ? fb_x_t'(FB_W - 1) : sum_x[7:0];
    clip_y = (sum_y > 8'(FB_H - 1)) ? fb_y_t'(FB_H - 1) : sum_y[6:0];
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    we_d    = we;
    wx_d    = wx;
    wy_d    = wy;
    wc_d    = wc;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d = cmd.x;
          xl_d = clip_x;
          yl_d = clip_y;
          if (cmd.w == 9'd0 || cmd.h == 8'd0) begin
            state_d = DONE;
          end else begin
            wx_d    = cmd.x;
            wy_d    = cmd.y;
            wc_d    = cmd.color;
            we_d    = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (fb_ready) begin
          if (wx < xl_q) begin
            wx_d = wx + 8'd1;
          end else if (wy < yl_q) begin
            wx_d = x0_q;
            wy_d = wy + 7'd1;
          end else begin
            we_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any fill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      xl_q      <= '0;
      yl_q      <= '0;
      we        <= 1'b0;
      wx        <= '0;
      wy        <= '0;
      wc        <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      xl_q      <= xl_d;
      yl_q      <= yl_d;
      we        <= we_d;
      wx        <= wx_d;
      wy        <= wy_d;
      wc        <= wc_d;
      done      <= done_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
    end
  end

endmodule
